mac_serial_param: RTL and testbench
===================================

Name: mac_serial_param

Overview:
- Parametrised bit-serial multiply-accumulate unit; next generation of the team's 16x16/40-bit shift-add MAC.
- Adds:
  - configurable operand and accumulator widths
  - a per-operation signed/unsigned mode
  - a start/busy/done handshake with back-to-back issue
  - an accumulator clear
- Sits beside the datapath sequencer, which issues one product per handshake and reads mac_acc after mac_done.

Parameters:
- DATA_W, 16: operand width in bits; must be >= 2.
- ACC_W, 40: accumulator width in bits; must be >= 2*DATA_W.
- CNT_W, $clog2(DATA_W)+1: bit_counter width (derived; do not override).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- a_in  in  DATA_W  multiplicand, sampled on accepted start
- b_in  in  DATA_W  multiplier, sampled on accepted start
- signed_mode  in  1  1 = two's-complement operands; sampled on accepted start
- mac_start  in  1  level request to begin a multiply-accumulate
- acc_clear  in  1  synchronous accumulator clear
- busy  out  1  high while an operation is in flight
- mac_done  out  1  one-cycle pulse when mac_acc has been updated
- mac_acc  out  ACC_W  accumulator
- bit_counter  out  CNT_W  current serial bit index
- overflow  out  1  sticky accumulate overflow flag (see Optional Feature)

Behaviour:
- Reset (reset=0, async):
  - state=IDLE
  - mac_acc, bit_counter, busy, mac_done, overflow all 0
  - internal operand/partial-product registers all 0
  - Reset mid-operation aborts the operation; no mac_done is produced.
- States: IDLE, RUN, ACC.
- IDLE:
  - mac_start=1 is accepted on the edge.
  - On acceptance, latch a_in, b_in, signed_mode and go to RUN with bit_counter=0 and busy=1.
- Signed operand handling:
  - When signed_mode=1, latch magnitudes |a|, |b| and neg = sign(a) XOR sign(b).
  - The most-negative operand's magnitude is 2^(DATA_W-1), held in DATA_W bits.
- RUN:
  - Each cycle: if multiplier bit[bit_counter]=1, partial += multiplicand << bit_counter (2*DATA_W-bit partial).
  - bit_counter increments each cycle.
  - After the cycle with bit_counter=DATA_W-1, go to ACC.
- ACC (one cycle):
  - product = neg ? -partial : partial.
  - Extend product to ACC_W: sign-extend if signed, zero-extend otherwise.
  - mac_acc <= mac_acc + product.
  - mac_done=1 during the cycle following this edge.
  - bit_counter returns to 0.
- Latency: start accepted at edge N → mac_acc valid and mac_done=1 after edge N+DATA_W+1.
- Back-to-back issue:
  - If mac_start=1 while in ACC, the new operands are latched on the same edge and the FSM goes directly to RUN.
  - Throughput is one product per DATA_W+1 cycles.
  - Otherwise ACC → IDLE and busy falls.
- mac_start while in RUN is ignored; latched operands do not change.
- Operand inputs changing after acceptance have no effect.
- acc_clear:
  - In IDLE or RUN: mac_acc <= 0 and overflow <= 0.
  - Coincident with ACC: mac_acc <= product (clear takes effect, then the add); overflow <= 0.
- Overflow/wrap (default build):
  - Accumulation wraps modulo 2^ACC_W.
  - overflow is tied 0.

Optional Feature:
- Macro MAC_SAT_EN.
- Defined: the ACC add saturates.
  - Unsigned: result > 2^ACC_W-1 → all-ones.
  - Signed: clamp to the most-positive or most-negative ACC_W value.
  - overflow is set on any saturation and held until acc_clear or reset.
- Undefined: wrap-around as above; overflow constant 0.

Test Plan:
- Unsigned product: reset low 5 cycles then released; a_in=0x8235, b_in=0x0003, signed_mode=0, pulse mac_start → mac_done after 17 edges; mac_acc=0x000001869F; busy high exactly 17 cycles.
- Signed product: a_in=0x8235, b_in=0x0003, signed_mode=1 from a cleared accumulator → mac_acc=0xFFFFFE869F. Also a_in=0x8000, b_in=0x8000 signed → mac_acc=0x0040000000.
- Back-to-back accumulate: mac_start held high; a_in=b_in=0x56CE, unsigned → first mac_done gives 0x001D6F0DC4; second mac_done 17 cycles later gives 0x003ADE1B88; no idle cycle between the two operations.
- Ignore and clear: mac_start pulsed mid-RUN → no extra mac_done. Then acc_clear asserted in the ACC cycle of a 0x0002*0x0003 op → mac_acc=0x0000000006.
- Overflow (ACC_W=32 override), 0xFFFF*0xFFFF unsigned issued twice:
  - without MAC_SAT_EN → mac_acc=0xFFFC0002, overflow=0
  - with MAC_SAT_EN → mac_acc=0xFFFFFFFF, overflow=1 until acc_clear
- Reset mid-operation: assert reset at bit_counter=7 → all outputs 0 immediately (asynchronous); no mac_done; a fresh start afterwards completes normally with the correct product.

Source files
------------

// File: rtl/mac_serial_param_if.sv
// Handshake/data bundle between the datapath sequencer and the serial MAC.
// master: sequencer side (drives operands, start, clear); slave: MAC side.
// Widths must match the parameters of the mac_serial_param instance it feeds.
interface mac_serial_param_if #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int CNT_W  = $clog2(DATA_W) + 1
);
  logic [DATA_W-1:0] a_in;
  logic [DATA_W-1:0] b_in;
  logic              signed_mode;
  logic              mac_start;
  logic              acc_clear;
  logic              busy;
  logic              mac_done;
  logic [ACC_W-1:0]  mac_acc;
  logic [CNT_W-1:0]  bit_counter;
  logic              overflow;

  modport master (
    output a_in, b_in, signed_mode, mac_start, acc_clear,
    input  busy, mac_done, mac_acc, bit_counter, overflow
  );

  modport slave (
    input  a_in, b_in, signed_mode, mac_start, acc_clear,
    output busy, mac_done, mac_acc, bit_counter, overflow
  );
endinterface

// File: rtl/mac_serial_param.sv
// Bit-serial shift-add multiply-accumulate, signed/unsigned per operation.
// Latency: start accepted at edge N -> mac_acc updated, mac_done pulse after edge N+DATA_W+1.
// Backpressure: start is accepted only in IDLE or ACC (back-to-back); ignored while busy in RUN.
// Build option MAC_SAT_EN: saturating accumulate with sticky overflow (otherwise wrap, overflow=0).
module mac_serial_param #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic              clk,
  input  logic              reset,
  mac_serial_param_if.slave bus
);

  localparam int PW = 2 * DATA_W;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_ACC} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_mcand;
  logic [DATA_W-1:0] r_mplier;
  logic              r_neg;
  logic              r_signed;
  logic [PW-1:0]     r_partial;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy;
  logic              r_done;
  logic [ACC_W-1:0]  r_acc;
  logic              r_ovf;

  logic              w_accept;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [DATA_W-1:0] w_a_mag;
  logic [DATA_W-1:0] w_b_mag;
  logic              w_bit;
  logic [PW-1:0]     w_addend;
  logic [PW-1:0]     w_prod;
  logic signed [PW-1:0] w_prod_s;
  logic [ACC_W-1:0]  w_prod_ext;
  logic [ACC_W-1:0]  w_base;
  logic [ACC_W-1:0]  w_acc_nxt;
  logic              w_ovf_nxt;

  // A new operation may start from IDLE or straight out of ACC.
  assign w_accept = bus.mac_start && ((r_state == S_IDLE) || (r_state == S_ACC));

  // Signed operands are reduced to magnitudes; the sign is re-applied once in ACC.
  // The most-negative value maps to 2^(DATA_W-1), which still fits unsigned.
  assign w_a_neg = bus.signed_mode & bus.a_in[DATA_W-1];
  assign w_b_neg = bus.signed_mode & bus.b_in[DATA_W-1];
  assign w_a_mag = w_a_neg ? -bus.a_in : bus.a_in;
  assign w_b_mag = w_b_neg ? -bus.b_in : bus.b_in;

  // Serial step: current multiplier bit selects the shifted multiplicand.
  assign w_bit    = |(r_mplier & (DATA_W'(1) << r_cnt));
  assign w_addend = {{DATA_W{1'b0}}, r_mcand} << r_cnt;

  // Final product with sign restored, then extended to accumulator width.
  assign w_prod   = r_neg ? -r_partial : r_partial;
  assign w_prod_s = w_prod;
  assign w_prod_ext = r_signed ? ACC_W'(w_prod_s) : ACC_W'(w_prod);

  // A clear coinciding with ACC zeroes the old value before the add.
  assign w_base = bus.acc_clear ? '0 : r_acc;

`ifdef MAC_SAT_EN
  logic [ACC_W:0] w_sum;
  logic           w_u_ovf;
  logic           w_s_ovf;

  assign w_sum   = {1'b0, w_base} + {1'b0, w_prod_ext};
  assign w_u_ovf = w_sum[ACC_W];
  assign w_s_ovf = (w_base[ACC_W-1] == w_prod_ext[ACC_W-1]) &&
                   (w_sum[ACC_W-1] != w_base[ACC_W-1]);

  // Clamp the add on overflow and raise the sticky flag.
  always_comb begin
    w_acc_nxt = w_sum[ACC_W-1:0];
    w_ovf_nxt = bus.acc_clear ? 1'b0 : r_ovf;
    if (r_signed && w_s_ovf) begin
      w_acc_nxt = w_prod_ext[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                      : {1'b0, {(ACC_W-1){1'b1}}};
      w_ovf_nxt = 1'b1;
    end else if (!r_signed && w_u_ovf) begin
      w_acc_nxt = '1;
      w_ovf_nxt = 1'b1;
    end
  end
`else
  assign w_acc_nxt = w_base + w_prod_ext;
  assign w_ovf_nxt = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state: RUN for DATA_W cycles, one ACC cycle, then IDLE or chain into RUN.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.mac_start) w_state_nxt = S_RUN;
      S_RUN:   if (r_cnt == LAST_BIT) w_state_nxt = S_ACC;
      S_ACC:   w_state_nxt = bus.mac_start ? S_RUN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, serial partial-product build, counter and busy/done flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_neg     <= 1'b0;
      r_signed  <= 1'b0;
      r_partial <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= (r_state == S_ACC);
      if (w_accept) begin
        r_mcand   <= w_a_mag;
        r_mplier  <= w_b_mag;
        r_neg     <= w_a_neg ^ w_b_neg;
        r_signed  <= bus.signed_mode;
        r_partial <= '0;
        r_cnt     <= '0;
        r_busy    <= 1'b1;
      end else if (r_state == S_RUN) begin
        if (w_bit) r_partial <= r_partial + w_addend;
        r_cnt <= r_cnt + CNT_W'(1);
      end else if (r_state == S_ACC) begin
        r_cnt  <= '0;
        r_busy <= 1'b0;
      end
    end
  end

  // Accumulator and overflow: updated in ACC, otherwise only cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (r_state == S_ACC) begin
      r_acc <= w_acc_nxt;
      r_ovf <= w_ovf_nxt;
    end else if (bus.acc_clear) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end
  end

  assign bus.busy        = r_busy;
  assign bus.mac_done    = r_done;
  assign bus.mac_acc     = r_acc;
  assign bus.bit_counter = r_cnt;
  assign bus.overflow    = r_ovf;

endmodule

// File: tb/tb_mac_serial_param.sv
// Bench for mac_serial_param: directed vector table, multi-cycle corner sequences,
// and randomized operations scored against an arithmetic accumulator model.
// A second instance with ACC_W=32 exercises wrap/saturation (MAC_SAT_EN aware).
module tb_mac_serial_param;

  logic clk;
  logic rst_n;

  mac_serial_param_if #(.DATA_W(16), .ACC_W(40)) bus ();
  mac_serial_param_if #(.DATA_W(16), .ACC_W(32)) bus32 ();

  mac_serial_param #(.DATA_W(16), .ACC_W(40)) u_dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus)
  );

  mac_serial_param #(.DATA_W(16), .ACC_W(32)) u_dut32 (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit sel32    = 1'b0;

  localparam longint M40  = 64'h0000_00FF_FFFF_FFFF;
  localparam longint SMAX = 64'h0000_007F_FFFF_FFFF;
  localparam longint SMIN = -64'sh0000_0080_0000_0000;

  longint m_acc = 0;
  bit     m_ovf = 1'b0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic        clr;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] cur_acc();
    return sel32 ? 64'(bus32.mac_acc) : 64'(bus.mac_acc);
  endfunction
  function automatic logic cur_done();
    return sel32 ? bus32.mac_done : bus.mac_done;
  endfunction
  function automatic logic cur_busy();
    return sel32 ? bus32.busy : bus.busy;
  endfunction
  function automatic logic cur_ovf();
    return sel32 ? bus32.overflow : bus.overflow;
  endfunction

  task automatic set_in(input logic [15:0] a, input logic [15:0] b, input logic s, input logic st);
    if (sel32) begin
      bus32.a_in = a; bus32.b_in = b; bus32.signed_mode = s; bus32.mac_start = st;
    end else begin
      bus.a_in = a; bus.b_in = b; bus.signed_mode = s; bus.mac_start = st;
    end
  endtask

  task automatic set_clr(input logic c);
    if (sel32) bus32.acc_clear = c;
    else       bus.acc_clear = c;
  endtask

  task automatic do_clear();
    @(negedge clk); set_clr(1'b1);
    @(posedge clk); #1; set_clr(1'b0);
  endtask

  // Issue one operation, scramble inputs after acceptance, wait (bounded) for done.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                        output int lat, output int busy_cyc, output logic [63:0] acc);
    @(negedge clk); set_in(a, b, s, 1'b1);
    @(posedge clk); #1;
    set_in(16'($urandom), 16'($urandom), ~s, 1'b0);
    busy_cyc = cur_busy() ? 1 : 0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (cur_busy()) busy_cyc++;
      if (cur_done()) begin lat = k; break; end
    end
    acc = cur_acc();
  endtask

  // Reference: exact integer product, added to the accumulator with wrap or clamp.
  task automatic model_op(input logic [15:0] a, input logic [15:0] b, input logic s, input logic clr);
    longint p, base, sum;
    if (s) p = longint'($signed(a)) * longint'($signed(b));
    else   p = longint'(a) * longint'(b);
    if (clr) begin
      base  = 0;
      m_ovf = 1'b0;
    end else begin
      base = m_acc;
      if (s && base[39]) base = base - (64'sd1 <<< 40);
    end
    sum = base + p;
`ifdef MAC_SAT_EN
    if (s) begin
      if (sum > SMAX) begin sum = SMAX; m_ovf = 1'b1; end
      else if (sum < SMIN) begin sum = SMIN; m_ovf = 1'b1; end
    end else if (sum > M40) begin
      sum = M40; m_ovf = 1'b1;
    end
`endif
    m_acc = sum & M40;
  endtask

  function automatic logic [15:0] rnd_operand();
    case ($urandom_range(0, 5))
      0:       return 16'h8000;
      1:       return 16'hFFFF;
      2:       return 16'h7FFF;
      3:       return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bcyc, ndone, lat2;
    logic [63:0] acc;
    logic s, clr;
    logic [15:0] a, b;
    bit found;

    vecs[0] = '{16'h8235, 16'h0003, 1'b0, 1'b1, 64'h00_0001_869F};
    vecs[1] = '{16'h8235, 16'h0003, 1'b1, 1'b1, 64'hFF_FFFE_869F};
    vecs[2] = '{16'h8000, 16'h8000, 1'b1, 1'b1, 64'h00_4000_0000};
    vecs[3] = '{16'h56CE, 16'h56CE, 1'b0, 1'b1, 64'h00_1D6F_0DC4};
    vecs[4] = '{16'h56CE, 16'h56CE, 1'b0, 1'b0, 64'h00_3ADE_1B88};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 64'h00_0000_0001};
    vecs[6] = '{16'h0000, 16'h1234, 1'b1, 1'b1, 64'h00_0000_0000};

    rst_n = 1'b0;
    bus.a_in = '0; bus.b_in = '0; bus.signed_mode = 1'b0; bus.mac_start = 1'b0; bus.acc_clear = 1'b0;
    bus32.a_in = '0; bus32.b_in = '0; bus32.signed_mode = 1'b0; bus32.mac_start = 1'b0; bus32.acc_clear = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("reset acc",  64'(bus.mac_acc), 64'h0);
    check("reset busy", 64'(bus.busy), 64'h0);
    check("reset done", 64'(bus.mac_done), 64'h0);
    check("reset cnt",  64'(bus.bit_counter), 64'h0);
    check("reset ovf",  64'(bus.overflow), 64'h0);
    @(negedge clk); rst_n = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].clr) do_clear();
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, lat, bcyc, acc);
      check($sformatf("vec%0d acc", i), acc, vecs[i].exp);
      check($sformatf("vec%0d latency", i), 64'(lat), 64'd17);
      check($sformatf("vec%0d busy cycles", i), 64'(bcyc), 64'd17);
    end

    // Back-to-back: start held through the first ACC cycle.
    do_clear();
    @(negedge clk); set_in(16'h56CE, 16'h56CE, 1'b0, 1'b1);
    @(posedge clk); #1;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (bus.mac_done) begin lat = k; break; end
    end
    check("b2b first latency", 64'(lat), 64'd17);
    check("b2b first acc", 64'(bus.mac_acc), 64'h00_1D6F_0DC4);
    check("b2b busy kept", 64'(bus.busy), 64'h1);
    set_in(16'h56CE, 16'h56CE, 1'b0, 1'b0);
    lat2 = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (bus.mac_done) begin lat2 = k; break; end
    end
    check("b2b second spacing", 64'(lat2), 64'd17);
    check("b2b second acc", 64'(bus.mac_acc), 64'h00_3ADE_1B88);
    check("b2b busy falls", 64'(bus.busy), 64'h0);

    // Start pulse mid-RUN is ignored; clear coincident with ACC keeps only the new product.
    @(negedge clk); set_in(16'h0002, 16'h0003, 1'b0, 1'b1);
    @(posedge clk); #1; set_in(16'h0002, 16'h0003, 1'b0, 1'b0);
    lat = 1;
    repeat (4) begin @(posedge clk); lat++; end
    @(negedge clk); set_in(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
    @(posedge clk); lat++; #1; set_in(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); lat++; #1;
      if (bus.mac_done) begin found = 1'b1; set_clr(1'b0); break; end
      if (bus.bit_counter == 5'd16) set_clr(1'b1);
    end
    set_clr(1'b0);
    check("ignore latency", found ? 64'(lat - 1) : 64'hDEAD, 64'd17);
    check("clear in ACC acc", 64'(bus.mac_acc), 64'h6);
    ndone = 0;
    repeat (30) begin @(posedge clk); #1; if (bus.mac_done) ndone++; end
    check("no extra done", 64'(ndone), 64'd0);
    check("acc stable", 64'(bus.mac_acc), 64'h6);

    // Overflow on the 32-bit accumulator instance.
    sel32 = 1'b1;
    do_clear();
    run_op(16'hFFFF, 16'hFFFF, 1'b0, lat, bcyc, acc);
    check("ovf32 first acc", acc, 64'hFFFE_0001);
    check("ovf32 first flag", 64'(cur_ovf()), 64'h0);
    run_op(16'hFFFF, 16'hFFFF, 1'b0, lat, bcyc, acc);
`ifdef MAC_SAT_EN
    check("ovf32 sat acc", acc, 64'hFFFF_FFFF);
    check("ovf32 sat flag", 64'(cur_ovf()), 64'h1);
    repeat (5) @(posedge clk);
    #1;
    check("ovf32 flag sticky", 64'(cur_ovf()), 64'h1);
    do_clear();
    check("ovf32 flag cleared", 64'(cur_ovf()), 64'h0);
`else
    check("ovf32 wrap acc", acc, 64'hFFFC_0002);
    check("ovf32 wrap flag", 64'(cur_ovf()), 64'h0);
`endif
    sel32 = 1'b0;

    // Asynchronous reset in the middle of RUN.
    @(negedge clk); set_in(16'h1234, 16'h0005, 1'b0, 1'b1);
    @(posedge clk); #1; set_in(16'h1234, 16'h0005, 1'b0, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.bit_counter == 5'd7) begin found = 1'b1; break; end
    end
    check("reached bit 7", 64'(found), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    check("async rst acc",  64'(bus.mac_acc), 64'h0);
    check("async rst busy", 64'(bus.busy), 64'h0);
    check("async rst cnt",  64'(bus.bit_counter), 64'h0);
    check("async rst done", 64'(bus.mac_done), 64'h0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    ndone = 0;
    repeat (20) begin @(posedge clk); #1; if (bus.mac_done) ndone++; end
    check("aborted op no done", 64'(ndone), 64'd0);
    m_acc = 0; m_ovf = 1'b0;
    run_op(16'h1234, 16'h0005, 1'b0, lat, bcyc, acc);
    model_op(16'h1234, 16'h0005, 1'b0, 1'b0);
    check("post-reset acc", acc, 64'(m_acc));
    check("post-reset latency", 64'(lat), 64'd17);

    // Randomized operations against the model.
    for (int i = 0; i < 40; i++) begin
      a   = rnd_operand();
      b   = rnd_operand();
      s   = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 3) == 0);
      if (clr) do_clear();
      run_op(a, b, s, lat, bcyc, acc);
      model_op(a, b, s, clr);
      check($sformatf("rand%0d acc a=%h b=%h s=%0d", i, a, b, s), acc, 64'(m_acc));
      check($sformatf("rand%0d ovf", i), 64'(bus.overflow), 64'(m_ovf));
      check($sformatf("rand%0d latency", i), 64'(lat), 64'd17);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
